stop_watch: RTL and testbench
=============================

Name: stop_watch

Overview:
- Stopwatch with minutes / seconds / centiseconds resolution, driven by one system clock (50 MHz nominal, 20 ns period).
- Two active-low push-button inputs: fStart toggles run/pause; fStop halts the watch and clears it to zero.
- Three binary time outputs feed a downstream display/decoder block, which is not part of this block.

Parameters:
- TICK_DIV, 500000, clock cycles per 10 ms centisecond tick (50 MHz / 100). Must be >= 2.

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- fStart  input  1  start/pause button, active-low, asynchronous to Clk, idle high.
- fStop  input  1  stop/clear button, active-low, asynchronous to Clk, idle high.
- oMin  output  6  minutes, 0..59, binary.
- oSec  output  6  seconds, 0..59, binary.
- oCsec  output  7  centiseconds, 0..99, binary.

Behaviour:
- Reset (Rst=0, async):
  - State is IDLE.
  - Prescaler, oMin, oSec and oCsec are all 0.
  - Synchronizer and edge registers load 1 (button-released level).
- Button input path:
  - Each button passes through a 2-FF synchronizer, then a history register.
  - A press event is a synchronized 1->0 transition: a one-cycle pulse.
  - A button held low produces exactly one event. No further event occurs until it returns high and falls again.
  - Latency: the state change takes effect on the 3rd rising Clk edge after the input falls, with setup met.
- States: IDLE, RUN, PAUSE.
  - IDLE --start event--> RUN.
  - RUN --start event--> PAUSE.
  - PAUSE --start event--> RUN.
  - Any state --stop event--> IDLE. Prescaler and all outputs clear to 0 on that same edge.
  - Start and stop events on the same cycle: stop wins.
- Prescaler:
  - Counts 0..TICK_DIV-1, only in RUN.
  - Holds its value in PAUSE, so sub-tick progress is kept and resuming does not lose a partial tick.
  - Is 0 in IDLE.
  - When it reaches TICK_DIV-1 in RUN, it wraps to 0 and issues one tick.
- Time counters, advanced by one tick:
  - oCsec increments. At 99 it wraps to 0 and carries to oSec.
  - oSec increments on carry. At 59 it wraps to 0 and carries to oMin.
  - oMin increments on carry. At 59 it wraps to 0, so 59:59.99 -> 00:00.00 with no overflow flag.
- Time counters change only on a tick or a stop event. In PAUSE and IDLE the outputs are held stable.
- Outputs are registered and glitch-free. No combinational path from inputs to outputs.
- The first tick after IDLE->RUN occurs TICK_DIV cycles after entering RUN.

Test Plan:
- Reset: hold Rst=0 for 2 cycles with fStart/fStop=1 -> oMin=0, oSec=0, oCsec=0, state IDLE. Release Rst: outputs stay 0 with no button activity.
- Start/count, TICK_DIV=500000: pulse fStart low for 1 cycle (20 ns), wait 1.000 s -> oCsec=0, oSec=1, oMin=0, within 1 tick. After 61.00 s -> oMin=1, oSec=1.
- Held button: press fStart, then drive it low again 222.2 ms later and hold it low for 2 s -> exactly one pause event. Outputs freeze at 00:00.22 and stay there while the button is held.
- Resume: release fStart, press again -> counting resumes from 00:00.22 (prescaler value retained). After 0.78 s of RUN -> 00:01.00.
- Stop/clear: while RUN at a non-zero time, pulse fStop low -> on the 3rd edge all outputs are 0, state IDLE. A following fStart press restarts from 00:00.00. fStart and fStop falling together -> IDLE, outputs 0.
- Wrap, TICK_DIV=2 for fast sim: run 360000 ticks -> outputs return to 00:00.00. Check 00:00.99->00:01.00 and 00:59.99->01:00.00 carries. Assert async Rst mid-count -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stop_watch.sv
// Stopwatch (min:sec.csec). Two active-low buttons: fStart toggles run/pause,
// fStop clears to zero. Buttons are synchronized and edge-detected on their falling edge.
module stop_watch #(
  parameter int TICK_DIV = 500000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       fStart,
  input  logic       fStop,
  output logic [5:0] oMin,
  output logic [5:0] oSec,
  output logic [6:0] oCsec
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  logic [1:0]    start_sync, stop_sync;
  logic          start_hist, stop_hist;
  logic          start_ev, stop_ev;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic          tick;

  // 2-FF synchronizer plus history register; released level is 1
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      start_sync <= 2'b11;
      stop_sync  <= 2'b11;
      start_hist <= 1'b1;
      stop_hist  <= 1'b1;
    end else begin
      start_sync <= {start_sync[0], fStart};
      stop_sync  <= {stop_sync[0], fStop};
      start_hist <= start_sync[1];
      stop_hist  <= stop_sync[1];
    end
  end

  assign start_ev = start_hist & ~start_sync[1];
  assign stop_ev  = stop_hist  & ~stop_sync[1];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_ev) begin
      state_d = IDLE;
    end else if (start_ev) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  assign tick = (state_q == RUN) && (presc_q == PMAX);

  // Prescaler only advances while running, so a pause keeps partial-tick progress
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                  presc_q <= '0;
    else if (stop_ev)          presc_q <= '0;
    else if (tick)             presc_q <= '0;
    else if (state_q == RUN)   presc_q <= presc_q + PW'(1);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      oMin  <= '0;
      oSec  <= '0;
      oCsec <= '0;
    end else if (stop_ev) begin
      oMin  <= '0;
      oSec  <= '0;
      oCsec <= '0;
    end else if (tick) begin
      if (oCsec == 7'd99) begin
        oCsec <= '0;
        if (oSec == 6'd59) begin
          oSec <= '0;
          oMin <= (oMin == 6'd59) ? 6'd0 : oMin + 6'd1;
        end else begin
          oSec <= oSec + 6'd1;
        end
      end else begin
        oCsec <= oCsec + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_stop_watch.sv
// Bench for stop_watch: elapsed-run-cycle model plus directed button sequences
// with hand-computed time literals.
module tb_stop_watch;

  localparam int TD = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       fStart = 1'b1;
  logic       fStop = 1'b1;
  logic [5:0] oMin, oSec;
  logic [6:0] oCsec;

  int checks = 0;
  int errors = 0;

  stop_watch #(.TICK_DIV(TD)) dut (
    .Clk(Clk), .Rst(Rst), .fStart(fStart), .fStop(fStop),
    .oMin(oMin), .oSec(oSec), .oCsec(oCsec)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a button press takes effect two edges after its low level is first
  // sampled; displayed time is total RUN cycles / TD split into min/sec/csec.
  int   m_mode = 0;          // 0 idle, 1 run, 2 pause
  int   m_run  = 0;          // clock edges spent in RUN since last clear
  logic s1 = 1, s2 = 1, s3 = 1;   // start samples from edges k-1, k-2, k-3
  logic p1 = 1, p2 = 1, p3 = 1;   // stop samples

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_mode = 0; m_run = 0;
      s1 = 1; s2 = 1; s3 = 1;
      p1 = 1; p2 = 1; p3 = 1;
    end else begin
      automatic bit st_ev = (s2 == 1'b0) && (s3 == 1'b1);
      automatic bit sp_ev = (p2 == 1'b0) && (p3 == 1'b1);
      if (sp_ev) begin
        m_mode = 0; m_run = 0;
      end else begin
        if (m_mode == 1) m_run++;
        if (st_ev) m_mode = (m_mode == 1) ? 2 : 1;
      end
      s3 = s2; s2 = s1; s1 = fStart;
      p3 = p2; p2 = p1; p1 = fStop;
    end
  end

  always @(negedge Clk) begin
    automatic int t = m_run / TD;
    chk("model_csec", 32'(oCsec), 32'(t % 100));
    chk("model_sec",  32'(oSec),  32'((t / 100) % 60));
    chk("model_min",  32'(oMin),  32'((t / 6000) % 60));
  end

  task automatic lit(input string nm, input int mn, input int sc, input int cs);
    chk({nm, "_min"},  32'(oMin),  32'(mn));
    chk({nm, "_sec"},  32'(oSec),  32'(sc));
    chk({nm, "_csec"}, 32'(oCsec), 32'(cs));
  endtask

  // Called at a negedge; low level spans exactly one rising edge.
  task automatic press(input bit st, input bit sp);
    if (st) fStart = 1'b0;
    if (sp) fStop = 1'b0;
    @(negedge Clk);
    fStart = 1'b1;
    fStop  = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    lit("in_reset", 0, 0, 0);
    Rst = 1'b1;
    repeat (5) @(negedge Clk);
    lit("idle_after_reset", 0, 0, 0);

    // Start: RUN begins two edges after the sampled press; 400 ticks later -> 00:04.00
    press(1, 0);
    repeat (1602) @(posedge Clk);
    @(negedge Clk);
    lit("run_4s", 0, 4, 0);

    // Held button: exactly one pause event, display frozen
    fStart = 1'b0;
    repeat (40) @(negedge Clk);
    fStart = 1'b1;
    lit("held_pause", 0, 4, 0);
    repeat (5) @(negedge Clk);
    lit("pause_stable", 0, 4, 0);

    // Resume: prescaler kept 3 of 4 counts, so the next tick is one RUN edge away
    press(1, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    lit("resume_entry", 0, 4, 0);
    @(posedge Clk);
    @(negedge Clk);
    lit("resume_tick", 0, 4, 1);

    // Stop clears on the third edge
    repeat (100) @(negedge Clk);
    press(0, 1);
    @(posedge Clk);
    @(negedge Clk);
    chk("stop_not_yet", 32'(oCsec == 0 && oSec == 0 && oMin == 0), 32'(0));
    @(posedge Clk);
    @(negedge Clk);
    lit("stop_clear", 0, 0, 0);
    repeat (10) @(negedge Clk);
    lit("stop_idle", 0, 0, 0);

    // Restart, then simultaneous start+stop: stop wins
    press(1, 0);
    repeat (50) @(negedge Clk);
    press(1, 1);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    lit("both_clear", 0, 0, 0);
    repeat (10) @(negedge Clk);
    lit("both_idle", 0, 0, 0);

    // Long run: csec->sec carry at 100 ticks, sec->min carry at 6000 ticks
    press(1, 0);
    repeat (402) @(posedge Clk);
    @(negedge Clk);
    lit("carry_sec", 0, 1, 0);
    repeat (23600) @(posedge Clk);
    @(negedge Clk);
    lit("carry_min", 1, 0, 0);

    // Async reset mid-count clears without a clock edge
    repeat (37) @(negedge Clk);
    #3 Rst = 1'b0;
    #1 lit("async_rst", 0, 0, 0);
    @(negedge Clk);
    Rst = 1'b1;
    repeat (5) @(negedge Clk);
    lit("post_rst_idle", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
